// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that lets two requesters share one external comparator.
// Each accepted compare walks IDLE -> CMP -> RESP, so a new request can be accepted every 3 cycles.
module cmp_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [1:0]    req0_op,
    input  logic [1:0]    req1_op,
    output logic [DW-1:0] cmp_a,
    output logic [DW-1:0] cmp_b,
    input  logic [3:0]    cmp_flags,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic          rsp_result,
    output logic [3:0]    rsp_flags,
    output logic          rsp_id,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshake: a request transfers on a rising edge where reqN_valid and
    // reqN_ready are both high. Ready is only ever raised in IDLE, for at most
    // one requester, and only when that requester is valid. A requester holds
    // valid and operands until it is accepted. Responses have no backpressure:
    // rspN_valid is a one-cycle strobe qualifying rsp_flags/rsp_result/rsp_id.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_grant;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [1:0]    r_op;
    logic          r_id;
    logic [3:0]    r_flags;
    logic          r_result;
    logic          r_rsp_id;
    logic          w_grant_any;
    logic          w_grant_id;
    logic          w_sel_result;

    always_comb begin
        w_next      = r_state;
        w_grant_any = 1'b0;
        w_grant_id  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie the requester that did not win last time goes next.
                if (req0_valid && req1_valid) begin
                    w_grant_any = 1'b1;
                    w_grant_id  = ~r_last_grant;
                end else if (req0_valid) begin
                    w_grant_any = 1'b1;
                    w_grant_id  = 1'b0;
                end else if (req1_valid) begin
                    w_grant_any = 1'b1;
                    w_grant_id  = 1'b1;
                end
                if (w_grant_any) begin
                    w_next = S_CMP;
                end
            end
            S_CMP:   w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_result = 1'b0;
        case (r_op)
            2'b00: w_sel_result = cmp_flags[1];
            2'b01: w_sel_result = cmp_flags[0];
            2'b10: w_sel_result = cmp_flags[3];
            2'b11: w_sel_result = cmp_flags[2];
            default: w_sel_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 2'b00;
            r_id         <= 1'b0;
            r_flags      <= 4'b0000;
            r_result     <= 1'b0;
            r_rsp_id     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant_any) begin
                r_last_grant <= w_grant_id;
                r_id         <= w_grant_id;
                r_a          <= w_grant_id ? req1_a  : req0_a;
                r_b          <= w_grant_id ? req1_b  : req0_b;
                r_op         <= w_grant_id ? req1_op : req0_op;
            end
            // Response fields change only on entry to RESP and hold afterwards.
            if (r_state == S_CMP) begin
                r_flags  <= cmp_flags;
                r_result <= w_sel_result;
                r_rsp_id <= r_id;
            end
        end
    end

    assign req0_ready = w_grant_any & ~w_grant_id;
    assign req1_ready = w_grant_any &  w_grant_id;
    assign cmp_a      = r_a;
    assign cmp_b      = r_b;
    assign rsp0_valid = (r_state == S_RESP) & ~r_rsp_id;
    assign rsp1_valid = (r_state == S_RESP) &  r_rsp_id;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign rsp_id     = r_rsp_id;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule
